// File: rtl/screen_text_buffer_if.sv
// screen_text_buffer_if: CPU write, driver read and frame handshake signals. Rev 1.0
`default_nettype none

interface screen_text_buffer_if #(
  parameter int INDEX_WIDTH = 6
);
  logic [7:0]             cpuChar;
  logic [INDEX_WIDTH-1:0] cpuCharIndex;
  logic                   writeScreen;
  logic                   clearScreen;
  logic [INDEX_WIDTH-1:0] readIndex;
  logic                   readEnable;
  logic [7:0]             readChar;
  logic                   readValid;
  logic                   busy;
  logic                   frameDirty;
  logic                   frameAck;

  modport master (
    output cpuChar, cpuCharIndex, writeScreen, clearScreen,
    output readIndex, readEnable, frameAck,
    input  readChar, readValid, busy, frameDirty
  );

  modport slave (
    input  cpuChar, cpuCharIndex, writeScreen, clearScreen,
    input  readIndex, readEnable, frameAck,
    output readChar, readValid, busy, frameDirty
  );
endinterface

`default_nettype wire

// File: rtl/screen_text_buffer.sv
// screen_text_buffer: 64-cell text store with hardware clear sequencer and frame-dirty flag. Rev 1.0
`default_nettype none

module screen_text_buffer #(
  parameter int         CHAR_COUNT  = 64,
  parameter int         INDEX_WIDTH = 6,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  wire logic           clk,
  input  wire logic           resetN,
  screen_text_buffer_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [INDEX_WIDTH:0] LAST_PTR = (INDEX_WIDTH+1)'(CHAR_COUNT - 1);

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH:0]   clrPtr_q, clrPtr_d;
  logic [CHAR_COUNT-1:0]  protect_q, protect_d;
  logic [7:0]             readChar_q, readChar_d;
  logic                   readValid_q;
  logic                   frameDirty_q, frameDirty_d;
  logic [7:0]             mem_q [CHAR_COUNT];

  logic                   memWe;
  logic [INDEX_WIDTH-1:0] memAddr;
  logic [7:0]             memData;
  logic [INDEX_WIDTH-1:0] clrIdx;
  logic                   clearDone;
  logic [7:0]             readData;

  assign clrIdx = clrPtr_q[INDEX_WIDTH-1:0];

  // CPU write always owns the port; the sequencer only advances on idle port cycles.
  always_comb begin
    state_d      = state_q;
    clrPtr_d     = clrPtr_q;
    protect_d    = protect_q;
    frameDirty_d = frameDirty_q;
    memWe        = bus.writeScreen;
    memAddr      = bus.cpuCharIndex;
    memData      = bus.cpuChar;
    clearDone    = 1'b0;

    if (bus.clearScreen) begin
      state_d   = ST_CLEAR;
      clrPtr_d  = '0;
      protect_d = '0;
      if (bus.writeScreen) protect_d[bus.cpuCharIndex] = 1'b1;
    end else if (state_q == ST_CLEAR) begin
      if (bus.writeScreen) begin
        protect_d[bus.cpuCharIndex] = 1'b1;
      end else begin
        if (!protect_q[clrIdx]) begin
          memWe   = 1'b1;
          memAddr = clrIdx;
          memData = BLANK_CHAR;
        end
        clrPtr_d = clrPtr_q + 1'b1;
        if (clrPtr_q == LAST_PTR) begin
          state_d   = ST_IDLE;
          clearDone = 1'b1;
        end
      end
    end

    if (bus.frameAck) frameDirty_d = 1'b0;
    if (bus.writeScreen || clearDone) frameDirty_d = 1'b1;
  end

  // Cells the sequencer has not reached yet already look blank to the driver.
  always_comb begin
    readData = mem_q[bus.readIndex];
    if (state_q == ST_CLEAR && {1'b0, bus.readIndex} >= clrPtr_q && !protect_q[bus.readIndex])
      readData = BLANK_CHAR;
    if (bus.writeScreen && bus.cpuCharIndex == bus.readIndex)
      readData = bus.cpuChar;
    readChar_d = bus.readEnable ? readData : readChar_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_CLEAR;
      clrPtr_q     <= '0;
      protect_q    <= '0;
      readChar_q   <= 8'h00;
      readValid_q  <= 1'b0;
      frameDirty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clrPtr_q     <= clrPtr_d;
      protect_q    <= protect_d;
      readChar_q   <= readChar_d;
      readValid_q  <= bus.readEnable;
      frameDirty_q <= frameDirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem_q[memAddr] <= memData;
  end

  assign bus.readChar   = readChar_q;
  assign bus.readValid  = readValid_q;
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.frameDirty = frameDirty_q;

endmodule

`default_nettype wire

// File: tb/tb_screen_text_buffer.sv
// tb_screen_text_buffer: table vectors plus read scoreboard for screen_text_buffer. Rev 1.0
`default_nettype none

module tb_screen_text_buffer;

  typedef struct {
    logic [5:0] idx;
    logic [7:0] exp;
  } rd_vec_t;

  logic clk;
  logic resetN;
  int   n_cmp;
  int   n_bad;
  logic [7:0] exp_q [$];

  screen_text_buffer_if #(.INDEX_WIDTH(6)) bus ();

  screen_text_buffer #(
    .CHAR_COUNT (64),
    .INDEX_WIDTH(6),
    .BLANK_CHAR (8'h20)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read scoreboard: every readValid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetN && bus.readValid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: readValid=1 readChar=%02h, required no read outstanding", bus.readChar);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.readChar !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %02h, required %02h", bus.readChar, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [5:0] idx, input logic [7:0] exp);
    bus.readEnable = 1'b1;
    bus.readIndex  = idx;
    exp_q.push_back(exp);
    tick();
    bus.readEnable = 1'b0;
  endtask

  task automatic apply_table(input rd_vec_t tbl [$]);
    for (int i = 0; i < tbl.size(); i++) do_read(tbl[i].idx, tbl[i].exp);
    tick();
  endtask

  // Counts edges until busy drops; optional write/clear/read injected before a given edge.
  task automatic run_clear(input int wr_at, input logic [5:0] wr_idx, input logic [7:0] wr_dat,
                           input int clr_at, input int rd_at, input logic [5:0] rd_idx,
                           input logic [7:0] rd_exp, output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (k == wr_at) begin
        bus.writeScreen  = 1'b1;
        bus.cpuCharIndex = wr_idx;
        bus.cpuChar      = wr_dat;
      end
      if (k == clr_at) bus.clearScreen = 1'b1;
      if (k == rd_at) begin
        bus.readEnable = 1'b1;
        bus.readIndex  = rd_idx;
        exp_q.push_back(rd_exp);
      end
      tick();
      bus.writeScreen = 1'b0;
      bus.clearScreen = 1'b0;
      bus.readEnable  = 1'b0;
      n++;
      if (!bus.busy) break;
    end
  endtask

  initial begin
    rd_vec_t tbl_reset [$];
    rd_vec_t tbl_restart [$];
    int n;

    tbl_reset   = '{'{6'd0, 8'h20}, '{6'd31, 8'h20}, '{6'd63, 8'h20}};
    tbl_restart = '{'{6'd0, 8'h20}, '{6'd7, 8'h20}, '{6'd50, 8'h20}, '{6'd63, 8'h20}, '{6'd1, 8'h20}};

    n_cmp = 0;
    n_bad = 0;
    resetN           = 1'b0;
    bus.cpuChar      = 8'h00;
    bus.cpuCharIndex = '0;
    bus.writeScreen  = 1'b0;
    bus.clearScreen  = 1'b0;
    bus.readIndex    = '0;
    bus.readEnable   = 1'b0;
    bus.frameAck     = 1'b0;

    repeat (2) tick();
    check("rst_readChar", bus.readChar, 8'h00);
    check("rst_readValid", bus.readValid, 1'b0);
    check("rst_frameDirty", bus.frameDirty, 1'b0);
    check("rst_busy", bus.busy, 1'b1);

    // Plain clear after reset release
    resetN = 1'b1;
    run_clear(-1, 6'd0, 8'h00, -1, -1, 6'd0, 8'h00, n);
    check("clear_len_reset", n, 64);
    check("clear_dirty_rise", bus.frameDirty, 1'b1);
    apply_table(tbl_reset);

    // CPU write at cycle 5 of a clear
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    run_clear(4, 6'd50, 8'h41, -1, -1, 6'd0, 8'h00, n);
    check("clear_len_write", n, 65);
    for (int i = 0; i < 64; i++) do_read(6'(i), (i == 50) ? 8'h41 : 8'h20);
    tick();

    // Dirty handshake and read bypass
    bus.frameAck = 1'b1;
    tick();
    bus.frameAck = 1'b0;
    check("dirty_ack", bus.frameDirty, 1'b0);

    bus.writeScreen  = 1'b1;
    bus.cpuCharIndex = 6'd7;
    bus.cpuChar      = 8'h5A;
    bus.readEnable   = 1'b1;
    bus.readIndex    = 6'd7;
    exp_q.push_back(8'h5A);
    tick();
    bus.writeScreen = 1'b0;
    bus.readEnable  = 1'b0;
    check("bypass_valid", bus.readValid, 1'b1);
    check("dirty_write", bus.frameDirty, 1'b1);
    tick();
    check("read_hold_char", bus.readChar, 8'h5A);
    check("read_hold_valid", bus.readValid, 1'b0);

    bus.writeScreen  = 1'b1;
    bus.cpuCharIndex = 6'd9;
    bus.cpuChar      = 8'h66;
    bus.frameAck     = 1'b1;
    tick();
    bus.writeScreen = 1'b0;
    bus.frameAck    = 1'b0;
    check("dirty_set_wins", bus.frameDirty, 1'b1);
    bus.frameAck = 1'b1;
    tick();
    bus.frameAck = 1'b0;
    check("dirty_lone_ack", bus.frameDirty, 1'b0);
    do_read(6'd9, 8'h66);
    do_read(6'd7, 8'h5A);

    // Clear restart, with a masked read of the stale cell 0
    bus.writeScreen  = 1'b1;
    bus.cpuCharIndex = 6'd0;
    bus.cpuChar      = 8'h33;
    tick();
    bus.writeScreen = 1'b0;
    do_read(6'd0, 8'h33);
    bus.clearScreen = 1'b1;
    tick();
    bus.clearScreen = 1'b0;
    check("restart_busy_start", bus.busy, 1'b1);
    run_clear(-1, 6'd0, 8'h00, 19, 0, 6'd0, 8'h20, n);
    check("clear_len_restart", n, 84);
    apply_table(tbl_restart);

    // Async reset at cycle 30 of a clear
    bus.frameAck = 1'b1;
    bus.clearScreen = 1'b1;
    tick();
    bus.frameAck = 1'b0;
    bus.clearScreen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) begin
        bus.writeScreen  = 1'b1;
        bus.cpuCharIndex = 6'd3;
        bus.cpuChar      = 8'h77;
      end
      if (k == 29) begin
        bus.readEnable = 1'b1;
        bus.readIndex  = 6'd60;
      end
      tick();
      bus.writeScreen = 1'b0;
      bus.readEnable  = 1'b0;
    end
    check("pre_rst_valid", bus.readValid, 1'b1);
    check("pre_rst_char", bus.readChar, 8'h20);
    check("pre_rst_dirty", bus.frameDirty, 1'b1);
    resetN = 1'b0;
    #1;
    check("async_rst_valid", bus.readValid, 1'b0);
    check("async_rst_char", bus.readChar, 8'h00);
    check("async_rst_dirty", bus.frameDirty, 1'b0);
    check("async_rst_busy", bus.busy, 1'b1);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    run_clear(-1, 6'd0, 8'h00, -1, -1, 6'd0, 8'h00, n);
    check("clear_len_after_rst", n, 64);
    do_read(6'd3, 8'h20);
    do_read(6'd9, 8'h20);
    repeat (2) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
